instr_program_memory: RTL and testbench
=======================================

INSTR_PROGRAM_MEMORY -- requirements
Module: instr_program_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction word width in bits.
REQ-002 SHALL have parameter OFFS_W, default 4: word-offset width; each program region holds PROG_SIZE = 2**OFFS_W words.
REQ-003 SHALL have parameter PROG_W, default 2: program-select width; there are NUM_PROGS = 2**PROG_W regions, total depth NUM_PROGS*PROG_SIZE words.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port load_start, input, 1: begins loading of the region given by load_prog.
REQ-007 SHALL have port load_prog, input, PROG_W: target region; sampled only when load_start is accepted.
REQ-008 SHALL have port load_valid, input, 1: load_data holds a word to write.
REQ-009 SHALL have port load_data, input, DATA_W: word to write.
REQ-010 SHALL have port load_last, input, 1: qualifies the final word of a load.
REQ-011 SHALL have port load_ready, output, 1: high while in LOAD and the region is not full.
REQ-012 SHALL have port load_ovf, output, 1: sticky flag, set when a word is presented to a full region.
REQ-013 SHALL have port prog_sel, input, PROG_W: region used for fetches.
REQ-014 SHALL have port fetch_req, input, 1: fetch request.
REQ-015 SHALL have port fetch_addr, input, OFFS_W: word offset within the prog_sel region.
REQ-016 SHALL have port fetch_ready, output, 1: high only in IDLE.
REQ-017 SHALL have port instr, output, DATA_W: fetched instruction word.
REQ-018 SHALL have port instr_valid, output, 1: instr holds a fetch result.
REQ-019 SHALL have port fetch_err, output, 1: the fetch on instr this cycle went beyond the loaded length.

Function
REQ-020 SHALL implement a two-state FSM, IDLE and LOAD.
REQ-021 In IDLE, load_start SHALL move the FSM to LOAD and set wr_ptr = load_prog*PROG_SIZE and len[load_prog] = 0.
REQ-022 In LOAD, when load_valid is high and load_ready is high, the block SHALL write load_data at wr_ptr, increment wr_ptr and increment len[load_prog].
REQ-023 When a write occurs with load_last high, the FSM SHALL return to IDLE on the next cycle.
REQ-024 A region is full when its len equals PROG_SIZE; len is OFFS_W+1 bits wide and saturates at PROG_SIZE.
REQ-025 When load_valid is high and the region is full, the block SHALL discard the word, set load_ovf, and return to IDLE if load_last is high.
REQ-026 load_start SHALL be ignored while in LOAD.
REQ-027 A fetch is accepted when fetch_req and fetch_ready are both high in a cycle.
REQ-028 Fetch latency SHALL be 1 cycle: instr_valid is high in the cycle after acceptance, for exactly one cycle per accepted fetch.
REQ-029 Back-to-back fetches SHALL give one result per cycle.
REQ-030 If fetch_addr < len[prog_sel], instr SHALL be mem[prog_sel*PROG_SIZE + fetch_addr] and fetch_err SHALL be 0.
REQ-031 If fetch_addr >= len[prog_sel], instr SHALL be 0 (NOP), fetch_err SHALL be 1, and memory SHALL not be read.
REQ-032 A fetch and a load_start in the same IDLE cycle SHALL both be accepted; the fetch uses len values from before the load_start.
REQ-033 While instr_valid is low, instr SHALL hold its last value and fetch_err SHALL be 0.
REQ-034 Offset arithmetic SHALL never wrap into a neighbouring region.

Reset
REQ-035 While reset_n is low, the block SHALL be in IDLE.
REQ-036 While reset_n is low, every len entry SHALL be 0 and wr_ptr SHALL be 0.
REQ-037 While reset_n is low, load_ready, load_ovf, instr_valid and fetch_err SHALL be 0, and instr SHALL be 0.
REQ-038 Reset SHALL not clear the memory array, but the cleared len values make every word unreachable until it is reloaded.
REQ-039 If reset_n is asserted mid-load, the load SHALL be aborted, and after release the FSM SHALL be in IDLE with fetch_ready = 1.

Verification
REQ-040 Load: load region 1 with 3 words A, B, C, load_last on C; then fetch prog_sel = 1, addr 0, 1, 2 back-to-back -> A, B, C on consecutive cycles, each with instr_valid = 1 and fetch_err = 0.
REQ-041 Length limit: fetch prog_sel = 1, addr 3 -> instr = 0, fetch_err = 1, one cycle after the request.
REQ-042 Overflow: load region 0 with 17 words using default parameters -> load_ready = 0 after word 16, load_ovf = 1, and a fetch of addr 15 returns word 16.
REQ-043 Region isolation: load region 2 fully, then load region 3 -> region 2 contents are unchanged and len[2] = 16.
REQ-044 Load and fetch interaction: a fetch during LOAD has fetch_ready = 0 and no instr_valid; a load_start and a fetch in the same cycle -> the fetch result uses the old length.
REQ-045 Reset: assert reset_n low after 2 words of a load -> IDLE, every len = 0, and a fetch of addr 0 gives fetch_err = 1.

Source files
------------

// File: rtl/instr_program_memory.sv
// Instruction program memory: NUM_PROGS regions of PROG_SIZE words, loaded by a
// streaming write port and read by a one-cycle-latency fetch port bounded by each region's loaded length.
module instr_program_memory #(
    parameter int DATA_W = 32,
    parameter int OFFS_W = 4,
    parameter int PROG_W = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic [PROG_W-1:0] load_prog,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_ovf,
    input  logic [PROG_W-1:0] prog_sel,
    input  logic              fetch_req,
    input  logic [OFFS_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_err
);

    localparam int PROG_SIZE = 2 ** OFFS_W;
    localparam int NUM_PROGS = 2 ** PROG_W;
    localparam int DEPTH     = NUM_PROGS * PROG_SIZE;
    localparam int ADDR_W    = PROG_W + OFFS_W;
    localparam logic [OFFS_W:0] FULL_LEN = (OFFS_W + 1)'(PROG_SIZE);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PROG_W-1:0]   cur_prog_q, cur_prog_d;
    logic [OFFS_W:0]     len_q [NUM_PROGS];
    logic [OFFS_W:0]     len_d [NUM_PROGS];
    logic                load_ovf_q, load_ovf_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                instr_valid_q, instr_valid_d;
    logic                fetch_err_q, fetch_err_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;

    logic                cur_full;
    logic                fetch_accept;
    logic                fetch_in_range;

    assign cur_full       = (len_q[cur_prog_q] == FULL_LEN);
    assign load_ready     = (state_q == LOAD) && !cur_full;
    assign fetch_ready    = (state_q == IDLE);
    assign fetch_accept   = fetch_req && fetch_ready;
    // Fetch bound uses the pre-update lengths, so a same-cycle load_start cannot affect it.
    assign fetch_in_range = ({1'b0, fetch_addr} < len_q[prog_sel]);

    assign load_ovf    = load_ovf_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        cur_prog_d    = cur_prog_q;
        load_ovf_d    = load_ovf_q;
        mem_we        = 1'b0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            len_d[i] = len_q[i];
        end

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d          = LOAD;
                    cur_prog_d       = load_prog;
                    wr_ptr_d         = {load_prog, {OFFS_W{1'b0}}};
                    len_d[load_prog] = '0;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    // After the last slot wr_ptr rolls over, but a full region is never written again.
                    if (!cur_full) begin
                        mem_we            = 1'b1;
                        wr_ptr_d          = wr_ptr_q + 1'b1;
                        len_d[cur_prog_q] = len_q[cur_prog_q] + 1'b1;
                    end else begin
                        load_ovf_d = 1'b1;
                    end
                    if (load_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_d       = instr_q;
        instr_valid_d = fetch_accept;
        fetch_err_d   = fetch_accept && !fetch_in_range;
        if (fetch_accept) begin
            instr_d = fetch_in_range ? mem[{prog_sel, fetch_addr}] : '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            cur_prog_q    <= '0;
            load_ovf_q    <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            for (int i = 0; i < NUM_PROGS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            cur_prog_q    <= cur_prog_d;
            load_ovf_q    <= load_ovf_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            for (int i = 0; i < NUM_PROGS; i++) begin
                len_q[i] <= len_d[i];
            end
        end
    end

    // Storage is deliberately outside reset; cleared lengths make stale words unreachable.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= load_data;
        end
    end

endmodule

// File: tb/tb_instr_program_memory.sv
// Self-checking bench for instr_program_memory: directed scenarios plus random traffic,
// all compared against a per-region array model of loads, lengths and fetches.
module tb_instr_program_memory;

    localparam int DATA_W    = 32;
    localparam int OFFS_W    = 4;
    localparam int PROG_W    = 2;
    localparam int PROG_SIZE = 2 ** OFFS_W;
    localparam int NUM_PROGS = 2 ** PROG_W;

    logic              clock;
    logic              reset_n;
    logic              load_start;
    logic [PROG_W-1:0] load_prog;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_ovf;
    logic [PROG_W-1:0] prog_sel;
    logic              fetch_req;
    logic [OFFS_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fetch_err;

    int checks;
    int errors;

    logic [DATA_W-1:0] mem_m [NUM_PROGS][PROG_SIZE];
    int                len_m [NUM_PROGS];
    bit                in_load_m;
    int                cur_m;
    bit                ovf_m;
    logic [DATA_W-1:0] instr_m;
    bit                valid_m;
    bit                err_m;

    instr_program_memory #(
        .DATA_W(DATA_W),
        .OFFS_W(OFFS_W),
        .PROG_W(PROG_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_start  (load_start),
        .load_prog   (load_prog),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_ovf    (load_ovf),
        .prog_sel    (prog_sel),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        load_start = 1'b0;
        load_prog  = '0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        prog_sel   = '0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
    endtask

    task automatic resetModel();
        for (int p = 0; p < NUM_PROGS; p++) len_m[p] = 0;
        in_load_m = 1'b0;
        cur_m     = 0;
        ovf_m     = 1'b0;
        instr_m   = '0;
        valid_m   = 1'b0;
        err_m     = 1'b0;
    endtask

    // One clock with the currently driven inputs; model is advanced from pre-edge state.
    task automatic applyStimulus();
        bit nxt_in_load;
        checkOutput("load_ready", load_ready, in_load_m && (len_m[cur_m] < PROG_SIZE));
        checkOutput("fetch_ready", fetch_ready, !in_load_m);

        if (fetch_req && !in_load_m) begin
            valid_m = 1'b1;
            if (int'(fetch_addr) < len_m[prog_sel]) begin
                instr_m = mem_m[prog_sel][fetch_addr];
                err_m   = 1'b0;
            end else begin
                instr_m = '0;
                err_m   = 1'b1;
            end
        end else begin
            valid_m = 1'b0;
            err_m   = 1'b0;
        end

        nxt_in_load = in_load_m;
        if (!in_load_m) begin
            if (load_start) begin
                nxt_in_load     = 1'b1;
                cur_m           = int'(load_prog);
                len_m[load_prog] = 0;
            end
        end else if (load_valid) begin
            if (len_m[cur_m] < PROG_SIZE) begin
                mem_m[cur_m][len_m[cur_m]] = load_data;
                len_m[cur_m]++;
            end else begin
                ovf_m = 1'b1;
            end
            if (load_last) nxt_in_load = 1'b0;
        end
        in_load_m = nxt_in_load;

        @(posedge clock);
        #1;
        checkOutput("instr_valid", instr_valid, valid_m);
        checkOutput("fetch_err", fetch_err, err_m);
        checkOutput("instr", instr, instr_m);
        checkOutput("load_ovf", load_ovf, ovf_m);
    endtask

    task automatic doLoadStart(input int p);
        clearInputs();
        load_start = 1'b1;
        load_prog  = PROG_W'(p);
        applyStimulus();
        clearInputs();
    endtask

    task automatic doWrite(input logic [DATA_W-1:0] d, input bit last);
        clearInputs();
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        applyStimulus();
        clearInputs();
    endtask

    task automatic doFetch(input int p, input int a);
        clearInputs();
        fetch_req  = 1'b1;
        prog_sel   = PROG_W'(p);
        fetch_addr = OFFS_W'(a);
        applyStimulus();
        clearInputs();
    endtask

    task automatic applyReset();
        clearInputs();
        reset_n = 1'b0;
        #1;
        resetModel();
        checkOutput("rst_instr_valid", instr_valid, 1'b0);
        checkOutput("rst_fetch_err", fetch_err, 1'b0);
        checkOutput("rst_load_ready", load_ready, 1'b0);
        checkOutput("rst_load_ovf", load_ovf, 1'b0);
        checkOutput("rst_instr", instr, '0);
        checkOutput("rst_fetch_ready", fetch_ready, 1'b1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b1;
        clearInputs();
        resetModel();
        #2;
        applyReset();

        // Load region 1 with A, B, C and fetch them back to back.
        doLoadStart(1);
        doWrite(32'hAAAA_0001, 1'b0);
        doWrite(32'hBBBB_0002, 1'b0);
        doWrite(32'hCCCC_0003, 1'b1);
        doFetch(1, 0);
        checkOutput("abc_a", instr, 32'hAAAA_0001);
        doFetch(1, 1);
        checkOutput("abc_b", instr, 32'hBBBB_0002);
        doFetch(1, 2);
        checkOutput("abc_c", instr, 32'hCCCC_0003);
        checkOutput("abc_c_valid", instr_valid, 1'b1);

        doFetch(1, 3);
        checkOutput("limit_err", fetch_err, 1'b1);
        checkOutput("limit_instr", instr, '0);
        applyStimulus();
        checkOutput("limit_err_clear", fetch_err, 1'b0);

        // Overflow of region 0 with 17 words.
        doLoadStart(0);
        for (int i = 1; i <= 17; i++) begin
            doWrite(32'h1000_0000 + i, i == 17);
            if (i == 16) checkOutput("ovf_ready_low", load_ready, 1'b0);
        end
        checkOutput("ovf_flag", load_ovf, 1'b1);
        doFetch(0, 15);
        checkOutput("ovf_word16", instr, 32'h1000_0010);

        // Region isolation between regions 2 and 3.
        doLoadStart(2);
        for (int i = 0; i < PROG_SIZE; i++) doWrite(32'h2000_0000 + i, i == PROG_SIZE - 1);
        doLoadStart(3);
        for (int i = 0; i < 5; i++) doWrite(32'h3000_0000 + i, i == 4);
        for (int i = 0; i < PROG_SIZE; i++) doFetch(2, i);
        checkOutput("iso_last", instr, 32'h2000_000F);
        checkOutput("iso_len_full", fetch_err, 1'b0);

        // Fetch during LOAD, then fetch together with load_start.
        doLoadStart(3);
        doFetch(3, 0);
        checkOutput("load_fetch_novalid", instr_valid, 1'b0);
        doWrite(32'h3333_0000, 1'b1);
        clearInputs();
        load_start = 1'b1;
        load_prog  = 2'd1;
        fetch_req  = 1'b1;
        prog_sel   = 2'd1;
        fetch_addr = 4'd2;
        applyStimulus();
        clearInputs();
        checkOutput("same_cycle_old_len", instr, 32'hCCCC_0003);
        checkOutput("same_cycle_err", fetch_err, 1'b0);
        doWrite(32'h1111_0000, 1'b1);

        // Reset in the middle of a load.
        doLoadStart(2);
        doWrite(32'h4444_0000, 1'b0);
        doWrite(32'h4444_0001, 1'b0);
        applyReset();
        for (int p = 0; p < NUM_PROGS; p++) begin
            doFetch(p, 0);
            checkOutput("rst_len_err", fetch_err, 1'b1);
        end

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                applyReset();
            end else begin
                load_start = ($urandom_range(0, 11) == 0);
                load_prog  = PROG_W'($urandom);
                load_valid = ($urandom_range(0, 3) != 0);
                load_data  = $urandom;
                load_last  = ($urandom_range(0, 19) == 0);
                fetch_req  = $urandom_range(0, 1) == 1;
                prog_sel   = PROG_W'($urandom);
                fetch_addr = OFFS_W'($urandom);
                applyStimulus();
            end
        end
        clearInputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
